// File: rtl/custom_inverse_serial_pkg.sv
// Shared definitions for the inverse-direction serial ALU companion:
// operation encodings and controller states.
package custom_inv_pkg;

  typedef enum logic [1:0] {
    OP_LSR   = 2'b00,
    OP_LSL   = 2'b01,
    OP_ROR   = 2'b10,
    OP_THERM = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

endpackage

// File: rtl/custom_inverse_serial_if.sv
// Request/response bundle between the ALU datapath and the inverse serial unit.
interface custom_inverse_serial_if #(
  parameter int unsigned WIDTH = 4
);

  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [1:0]         op;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               busy;

  modport master (
    output in_valid, A, B, op, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, A, B, op, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/custom_inverse_serial_step.sv
// Single-bit step of the selected inverse operation; applied once per RUN cycle.
module custom_inv_step
  import custom_inv_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  op_e              op,
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  always_comb begin
    nxt = cur;
    case (op)
      OP_LSR:   nxt = cur >> 1;
      OP_LSL:   nxt = cur << 1;
      OP_ROR:   nxt = {cur[0], cur[WIDTH-1:1]};
      OP_THERM: nxt = {cur[WIDTH-2:0], 1'b1};
      default:  nxt = cur;
    endcase
  end

endmodule

// File: rtl/custom_inverse_serial.sv
// Multi-cycle inverse shift/rotate/thermometer-decode unit, one bit-step per clock,
// behind a valid/ready handshake; result zero-extended to 2*WIDTH.
module custom_inverse_serial
  import custom_inv_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic                    clk,
  input logic                    rst,
  custom_inverse_serial_if.slave bus
);

  localparam int unsigned SHW = $clog2(WIDTH);
  localparam int unsigned CW  = SHW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

  state_e           state, state_n;
  op_e              op_q, op_n;
  logic [WIDTH-1:0] work, work_n, step_work;
  logic [CW-1:0]    cnt, cnt_n, therm_cnt;
  logic             out_valid_q;
  logic [2*WIDTH-1:0] result_q;
  logic             accept, drain;

  custom_inv_step #(.WIDTH(WIDTH)) u_step (
    .op  (op_q),
    .cur (work),
    .nxt (step_work)
  );

  assign therm_cnt = (bus.B[SHW:0] > CNT_MAX) ? CNT_MAX : bus.B[SHW:0];

  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.busy      = (state != IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;

  assign accept = bus.in_valid && bus.in_ready;
  // Drain only once the registered out_valid has actually been presented.
  assign drain  = (state == DONE) && out_valid_q && bus.out_ready;

  generate
    if (WIDTH > CW) begin : g_unused_b
      logic unused_b_hi;
      assign unused_b_hi = ^bus.B[WIDTH-1:CW];
    end
  endgenerate

  always_comb begin
    state_n = state;
    op_n    = op_q;
    work_n  = work;
    cnt_n   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          op_n = op_e'(bus.op);
          if (bus.op == OP_THERM) begin
            work_n = '0;
            cnt_n  = therm_cnt;
          end else begin
            work_n = bus.A;
            cnt_n  = {1'b0, bus.B[SHW-1:0]};
          end
          state_n = (cnt_n == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        work_n = step_work;
        cnt_n  = cnt - CW'(1);
        if (cnt == CW'(1)) state_n = DONE;
      end
      DONE: begin
        if (drain) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      op_q        <= OP_LSR;
      work        <= '0;
      cnt         <= '0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
    end else begin
      state       <= state_n;
      op_q        <= op_n;
      work        <= work_n;
      cnt         <= cnt_n;
      out_valid_q <= (state == DONE) && !drain;
      result_q    <= ((state == DONE) && !drain) ? {{WIDTH{1'b0}}, work} : '0;
    end
  end

endmodule

// File: tb/tb_custom_inverse_serial.sv
// Self-checking bench for custom_inverse_serial: vector table plus hand-written corner sequences.
module tb_custom_inverse_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  custom_inverse_serial_if #(.WIDTH(4)) bus ();

  custom_inverse_serial #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] res;
    int         lat;
  } vec_t;

  typedef struct {
    logic [7:0] res;
    int         lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[16];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      tick();
      n++;
    end
    chk({name, " in_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  task automatic drive_req(input vec_t v);
    bus.op = v.op;
    bus.A  = v.a;
    bus.B  = v.b;
    bus.in_valid = 1'b1;
    sb.push_back('{res: v.res, lat: v.lat});
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid after the accept edge and check against the scoreboard head.
  task automatic collect(input string name);
    int   n = 0;
    exp_t e;
    while (!bus.out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({name, " out_valid"}, 32'(bus.out_valid), 32'd1);
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s scoreboard: got empty queue expected an entry", name);
    end else begin
      e = sb.pop_front();
      chk({name, " result"}, 32'(bus.result), 32'(e.res));
      chk({name, " latency"}, 32'(n), 32'(e.lat));
    end
  endtask

  task automatic drain_check(input string name);
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk({name, " drained out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({name, " drained result"}, 32'(bus.result), 32'd0);
    chk({name, " drained busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic do_req(input vec_t v, input string name);
    wait_ready(name);
    drive_req(v);
    collect(name);
    drain_check(name);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0]  = '{2'b10, 4'b1011, 4'd2,    8'h0E, 3};
    vecs[1]  = '{2'b10, 4'b1110, 4'd2,    8'h0B, 3};
    vecs[2]  = '{2'b00, 4'b1100, 4'd3,    8'h01, 4};
    vecs[3]  = '{2'b01, 4'b0011, 4'd1,    8'h06, 2};
    vecs[4]  = '{2'b11, 4'hA,    4'd3,    8'h07, 4};
    vecs[5]  = '{2'b11, 4'h5,    4'd4,    8'h0F, 5};
    vecs[6]  = '{2'b11, 4'h0,    4'd7,    8'h0F, 5};
    vecs[7]  = '{2'b11, 4'hF,    4'd0,    8'h00, 1};
    vecs[8]  = '{2'b00, 4'b1011, 4'd0,    8'h0B, 1};
    vecs[9]  = '{2'b10, 4'b0110, 4'd0,    8'h06, 1};
    vecs[10] = '{2'b01, 4'b1111, 4'd3,    8'h08, 4};
    vecs[11] = '{2'b00, 4'b0111, 4'd3,    8'h00, 4};
    vecs[12] = '{2'b10, 4'b0001, 4'd1,    8'h08, 2};
    vecs[13] = '{2'b10, 4'b1000, 4'd3,    8'h01, 4};
    vecs[14] = '{2'b10, 4'b0011, 4'b0110, 8'h0C, 3};
    vecs[15] = '{2'b11, 4'h0,    4'b1010, 8'h03, 3};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.A  = '0;
    bus.B  = '0;
    bus.op = '0;

    // Reset held for two cycles
    rst = 1'b1;
    tick();
    tick();
    chk("reset out_valid", 32'(bus.out_valid), 32'd0);
    chk("reset result", 32'(bus.result), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset in_ready", 32'(bus.in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", 32'(bus.in_ready), 32'd1);

    foreach (vecs[i]) do_req(vecs[i], $sformatf("vec%0d", i));

    // Backpressure with ignored requests while busy
    wait_ready("bp");
    drive_req('{2'b01, 4'b0001, 4'd2, 8'h04, 3});
    bus.in_valid = 1'b1;
    bus.op = 2'b11;
    bus.A  = 4'hF;
    bus.B  = 4'h0;
    chk("bp run in_ready", 32'(bus.in_ready), 32'd0);
    chk("bp run busy", 32'(bus.busy), 32'd1);
    collect("bp");
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp hold%0d result", k), 32'(bus.result), 32'h04);
      chk($sformatf("bp hold%0d out_valid", k), 32'(bus.out_valid), 32'd1);
      chk($sformatf("bp hold%0d in_ready", k), 32'(bus.in_ready), 32'd0);
    end
    drain_check("bp");
    chk("bp idle in_ready", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    tick();
    chk("bp no late accept", 32'(bus.busy), 32'd0);

    // out_ready held high before DONE
    bus.out_ready = 1'b1;
    wait_ready("early_rdy");
    drive_req('{2'b00, 4'b1000, 4'd2, 8'h02, 3});
    chk("early_rdy busy", 32'(bus.busy), 32'd1);
    collect("early_rdy");
    tick();
    bus.out_ready = 1'b0;
    chk("early_rdy single pulse", 32'(bus.out_valid), 32'd0);
    chk("early_rdy idle", 32'(bus.busy), 32'd0);

    // Reset mid-RUN aborts silently
    wait_ready("abort");
    bus.op = 2'b00;
    bus.A  = 4'b1000;
    bus.B  = 4'd3;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort busy", 32'(bus.busy), 32'd0);
    chk("abort result", 32'(bus.result), 32'd0);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.out_valid) n++;
      tick();
    end
    chk("abort no out_valid", 32'(n), 32'd0);
    do_req('{2'b00, 4'b1000, 4'd3, 8'h01, 4}, "after_abort");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
